uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the data-memory bus of the single-cycle RV32I core, in parallel with dmem and decoded by address. It consumes the same store/load signals the core drives into dmem: address = ALU result, store data = rs2, func3, wr_en and rd_en. Stored bytes are queued in a FIFO and serialised 8N1, LSB first, on a TX pin. Firmware polls a status register through ordinary loads; the core's write-back mux selects data_out when hit is high.

---
 rtl/uart_tx_mmio_if.sv | 20 ++
 rtl/uart_tx_mmio.sv | 156 +++++++++++++++
 tb/tb_uart_tx_mmio.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_mmio_if.sv
// Data-memory bus signals shared by the core, dmem and the memory-mapped UART transmitter.
interface uart_tx_mmio_if;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [2:0]  func3;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] data_out;
  logic        hit;

  modport master (
    output address, data_in, func3, wr_en, rd_en,
    input  data_out, hit
  );

  modport slave (
    input  address, data_in, func3, wr_en, rd_en,
    output data_out, hit
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a byte FIFO, STATUS is polled by loads.
module uart_tx_mmio #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_mmio_if.slave bus,
  output logic          tx
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_reg, state_next;
  logic [BW-1:0]   baud_reg, baud_next;
  logic [2:0]      bit_idx_reg, bit_idx_next;
  logic [7:0]      shifter_reg, shifter_next;
  logic            tx_reg, tx_next;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            overflow_reg;

  logic            width_ok, store_ok, push_req, push_ok, ovf_clear, pop;
  logic            full, empty, busy, bit_end;
  logic [31:0]     status;
  logic            unused_data;

  // Bus decode: only word-aligned addresses inside the 8-byte window respond.
  assign bus.hit   = (bus.address[31:3] == BASE_ADDR[31:3]) && (bus.address[1:0] == 2'b00);
  assign width_ok  = (bus.func3[2] == 1'b0) && (bus.func3[1:0] != 2'b11);
  assign store_ok  = bus.wr_en & bus.hit & width_ok;
  assign push_req  = store_ok & ~bus.address[2];
  assign ovf_clear = store_ok & bus.address[2] & bus.data_in[3];
  assign unused_data = ^bus.data_in[31:8];

  assign full    = (count_reg == COUNT_FULL);
  assign empty   = (count_reg == '0);
  assign busy    = (state_reg != IDLE);
  assign bit_end = (baud_reg == BAUD_LAST);
  // A same-edge pop frees a slot, so a push into a full FIFO still lands.
  assign push_ok = push_req & (~full | pop);

  assign status   = {16'h0, 8'(count_reg), 4'h0, overflow_reg, busy, empty, full};
  assign bus.data_out = (bus.rd_en && bus.hit && bus.address[2]) ? status : 32'h0;
  assign tx = tx_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= bus.data_in[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (push_req && !push_ok) begin
        overflow_reg <= 1'b1;
      end else if (ovf_clear) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shifter_reg <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      tx_reg      <= tx_next;
      // The FIFO head is read on the popping edge straight into the shifter.
      shifter_reg <= pop ? mem[rd_ptr_reg] : shifter_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_idx_next = bit_idx_reg;
    shifter_next = shifter_reg;
    tx_next      = 1'b1;
    pop          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          baud_next  = '0;
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_end) begin
          baud_next    = '0;
          bit_idx_next = '0;
          state_next   = DATA;
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      DATA: begin
        tx_next = shifter_reg[0];
        if (bit_end) begin
          baud_next    = '0;
          shifter_next = {1'b0, shifter_reg[7:1]};
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_next = '0;
          // Chain straight into the next start bit so frames stay contiguous.
          if (!empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_uart_tx_mmio;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  // Expected serial stream: frame f carries fb[f]; tx falls two edges after the origin edge f0.
  logic [7:0] fb [0:15];
  int         fnb = 0;
  int         f0 = 0;

  uart_tx_mmio_if bus();

  uart_tx_mmio #(
    .CLKS_PER_BIT (CPB),
    .BASE_ADDR    (BASE),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .tx  (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish by 200000, required finish earlier");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @edge %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic exp_tx(input int j);
    int f, p, k;
    if (j < 2) return 1'b1;
    f = (j - 2) / (10 * CPB);
    if (f >= fnb) return 1'b1;
    p = (j - 2) % (10 * CPB);
    k = p / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return fb[f][k-1];
    return 1'b1;
  endfunction

  task automatic watch_tx(input int last_edge);
    while (cyc < last_edge) begin
      @(negedge clk);
      chk("tx", {31'b0, tx}, {31'b0, exp_tx(cyc - f0)});
    end
  endtask

  // Called just after a negedge; the store lands on the next rising edge.
  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
    bus.address = addr;
    bus.data_in = data;
    bus.func3   = f3;
    bus.wr_en   = 1'b1;
    @(negedge clk);
    bus.wr_en   = 1'b0;
    bus.address = 32'h0;
  endtask

  task automatic load(input logic [31:0] addr, output logic [31:0] d, output logic h);
    bus.address = addr;
    bus.rd_en   = 1'b1;
    #1;
    d = bus.data_out;
    h = bus.hit;
    bus.rd_en   = 1'b0;
    bus.address = 32'h0;
  endtask

  logic [31:0] rd;
  logic        rh;
  int          n0;

  initial begin
    bus.address = 32'h0;
    bus.data_in = 32'h0;
    bus.func3   = 3'b010;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load(BASE + 32'd4, rd, rh);
    chk("reset_status", rd, 32'h0000_0002);
    chk("reset_status_hit", {31'b0, rh}, 32'h1);
    chk("reset_tx", {31'b0, tx}, 32'h1);
    #1;
    chk("idle_hit", {31'b0, bus.hit}, 32'h0);
    chk("idle_data_out", bus.data_out, 32'h0);

    // Single frame 0x55
    @(negedge clk);
    store(BASE, 32'h55, 3'b010);
    n0 = cyc; f0 = n0; fb[0] = 8'h55; fnb = 1;
    watch_tx(n0 + 40);
    load(BASE + 32'd4, rd, rh);
    chk("stop_bit_busy", rd, 32'h0000_0006);
    watch_tx(n0 + 41);
    load(BASE + 32'd4, rd, rh);
    chk("frame_done_idle", rd, 32'h0000_0002);
    watch_tx(n0 + 44);

    // Three back-to-back frames
    store(BASE, 32'h41, 3'b010);
    n0 = cyc;
    store(BASE, 32'h42, 3'b010);
    store(BASE, 32'h43, 3'b010);
    f0 = n0; fb[0] = 8'h41; fb[1] = 8'h42; fb[2] = 8'h43; fnb = 3;
    load(BASE + 32'd4, rd, rh);
    chk("b2b_count2", rd, 32'h0000_0204);
    watch_tx(n0 + 41);
    load(BASE + 32'd4, rd, rh);
    chk("b2b_count1", rd, 32'h0000_0104);
    watch_tx(n0 + 81);
    load(BASE + 32'd4, rd, rh);
    chk("b2b_count0", rd, 32'h0000_0006);
    watch_tx(n0 + 121);
    load(BASE + 32'd4, rd, rh);
    chk("b2b_idle", rd, 32'h0000_0002);
    watch_tx(n0 + 124);

    // Invalid accesses leave the FIFO untouched
    store(BASE, 32'hFF, 3'b100);
    load(BASE + 32'd4, rd, rh);
    chk("func3_100_ignored", rd, 32'h0000_0002);
    store(BASE, 32'hFF, 3'b011);
    load(BASE + 32'd4, rd, rh);
    chk("func3_011_ignored", rd, 32'h0000_0002);
    bus.address = BASE + 32'd1; bus.data_in = 32'hFF; bus.func3 = 3'b000; bus.wr_en = 1'b1;
    #1;
    chk("misaligned_hit", {31'b0, bus.hit}, 32'h0);
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.address = BASE + 32'd8; bus.wr_en = 1'b1;
    #1;
    chk("outside_hit", {31'b0, bus.hit}, 32'h0);
    @(negedge clk);
    bus.wr_en = 1'b0;
    load(BASE + 32'd4, rd, rh);
    chk("bad_addr_ignored", rd, 32'h0000_0002);
    bus.address = BASE + 32'd4; bus.rd_en = 1'b0;
    #1;
    chk("no_rd_en_data", bus.data_out, 32'h0);
    chk("no_rd_en_hit", {31'b0, bus.hit}, 32'h1);
    bus.address = 32'h0;
    load(BASE, rd, rh);
    chk("txdata_read_zero", rd, 32'h0);
    chk("txdata_read_hit", {31'b0, rh}, 32'h1);
    repeat (3) @(negedge clk);
    chk("invalid_tx_idle", {31'b0, tx}, 32'h1);

    // Overflow while mid-frame, then push on the STOP-end pop edge while full
    store(BASE, 32'hA0, 3'b000);
    n0 = cyc;
    repeat (3) @(negedge clk);
    for (int i = 1; i <= 8; i++) begin
      store(BASE, 32'(i), 3'(i % 3));
    end
    store(BASE, 32'h99, 3'b010);
    load(BASE + 32'd4, rd, rh);
    chk("overflow_full", rd, 32'h0000_080D);
    store(BASE + 32'd4, 32'hF7, 3'b010);
    load(BASE + 32'd4, rd, rh);
    chk("overflow_kept", rd, 32'h0000_080D);
    store(BASE + 32'd4, 32'h8, 3'b010);
    load(BASE + 32'd4, rd, rh);
    chk("overflow_cleared", rd, 32'h0000_0805);
    while (cyc < n0 + 40) @(negedge clk);
    store(BASE, 32'hEE, 3'b010);
    load(BASE + 32'd4, rd, rh);
    chk("full_push_pop", rd, 32'h0000_0805);
    f0 = n0; fb[0] = 8'hA0;
    for (int i = 1; i <= 8; i++) fb[i] = 8'(i);
    fb[9] = 8'hEE; fnb = 10;
    watch_tx(n0 + 401);
    load(BASE + 32'd4, rd, rh);
    chk("drain_idle", rd, 32'h0000_0002);
    watch_tx(n0 + 405);

    // Reset in the middle of data bit 3 with two bytes still queued
    store(BASE, 32'h00, 3'b010);
    n0 = cyc;
    store(BASE, 32'h5A, 3'b010);
    store(BASE, 32'h3C, 3'b010);
    while (cyc < n0 + 17) @(negedge clk);
    chk("pre_reset_tx", {31'b0, tx}, 32'h0);
    load(BASE + 32'd4, rd, rh);
    chk("pre_reset_status", rd, 32'h0000_0204);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_tx", {31'b0, tx}, 32'h1);
    load(BASE + 32'd4, rd, rh);
    chk("reset_mid_status", rd, 32'h0000_0002);
    rst = 1'b0;
    fnb = 0; f0 = cyc;
    watch_tx(cyc + 60);
    load(BASE + 32'd4, rd, rh);
    chk("post_reset_status", rd, 32'h0000_0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
